// File: rtl/pe_pkg.sv
// Shared encodings and sizing helpers for the MVM accumulate processing element.
package pe_pkg;

    localparam logic [1:0] TASK_DOT  = 2'b00;
    localparam logic [1:0] TASK_SUM  = 2'b01;
    localparam logic [1:0] TASK_MAX  = 2'b10;
    localparam logic [1:0] TASK_RSVD = 2'b11;

    typedef enum logic {StIdle, StOpen} pkt_state_e;

    // Smallest accumulator that holds a full-width dot product of one beat.
    function automatic int unsigned acc_min_width(input int unsigned data_width,
                                                  input int unsigned num_macs);
        return 2 * data_width + $clog2(num_macs);
    endfunction

endpackage

// File: rtl/pe_mvm_accum_if.sv
// Beat input and result output handshake bundle of pe_mvm_accum.
interface pe_mvm_accum_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_MACS   = 8,
    parameter int unsigned OUT_WIDTH  = 16
);
    logic                           in_valid;
    logic                           in_ready;
    logic [NUM_MACS*DATA_WIDTH-1:0] a;
    logic [NUM_MACS*DATA_WIDTH-1:0] b;
    logic                           in_first;
    logic                           in_last;
    logic [1:0]                     task_ctrl;
    logic                           out_valid;
    logic                           out_ready;
    logic [OUT_WIDTH-1:0]           result;
    logic                           overflow;
    logic                           proto_err;

    modport master (
        output in_valid, a, b, in_first, in_last, task_ctrl, out_ready,
        input  in_ready, out_valid, result, overflow, proto_err
    );

    modport slave (
        input  in_valid, a, b, in_first, in_last, task_ctrl, out_ready,
        output in_ready, out_valid, result, overflow, proto_err
    );

endinterface

// File: rtl/pe_reduce_tree.sv
// Combinational pairwise reduction of packed signed lane terms: sum or signed max.
module pe_reduce_tree #(
    parameter int unsigned  NUM_MACS = 8,
    parameter int unsigned  TERM_W   = 16,
    localparam int unsigned OUT_W    = TERM_W + $clog2(NUM_MACS)
) (
    input  logic [NUM_MACS*TERM_W-1:0] i_terms,
    input  logic                       i_is_max,
    output logic [OUT_W-1:0]           o_value
);

    always_comb begin : p_tree
        logic signed [OUT_W-1:0] w_node [NUM_MACS];
        for (int i = 0; i < NUM_MACS; i++) begin
            w_node[i] = OUT_W'($signed(i_terms[i*TERM_W +: TERM_W]));
        end
        // Level with stride s folds node i+s into node i.
        for (int s = 1; s < NUM_MACS; s = s * 2) begin
            for (int i = 0; i < NUM_MACS; i = i + 2 * s) begin
                if (i_is_max) begin
                    w_node[i] = (w_node[i+s] > w_node[i]) ? w_node[i+s] : w_node[i];
                end else begin
                    w_node[i] = w_node[i] + w_node[i+s];
                end
            end
        end
        o_value = w_node[0];
    end

endmodule

// File: rtl/pe_mvm_accum.sv
// Three-stage packet accumulator: lane terms, beat reduction, accumulate and saturate.
module pe_mvm_accum
    import pe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_MACS   = 8,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned OUT_SHIFT  = 0
) (
    input logic           clk,
    input logic           rst_n,
    pe_mvm_accum_if.slave bus
);

    localparam int unsigned TERM_W = 2 * DATA_WIDTH;
    localparam int unsigned RED_W  = acc_min_width(DATA_WIDTH, NUM_MACS);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    pkt_state_e r_state, w_state_next;
    logic [1:0] r_mode, w_beat_mode;
    logic       w_stall, w_accept, w_restart, w_orphan, w_rsvd_end, w_push;
    logic       r_proto_err;

    logic                       r_s1_valid, r_s1_first, r_s1_last;
    logic [1:0]                 r_s1_mode;
    logic [NUM_MACS*TERM_W-1:0] r_s1_terms, w_terms;
    logic [RED_W-1:0]           w_s1_value;

    logic                    r_s2_valid, r_s2_first, r_s2_last;
    logic [1:0]              r_s2_mode;
    logic signed [RED_W-1:0] r_s2_value;

    logic signed [ACC_WIDTH-1:0] r_acc, w_beat_ext, w_acc_next, w_shifted;
    logic                        w_sat_hi, w_sat_lo;
    logic [OUT_WIDTH-1:0]        r_result, w_result;
    logic                        r_out_valid, r_overflow;

    assign w_stall       = r_out_valid && !bus.out_ready;
    assign bus.in_ready  = rst_n && !w_stall;
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign w_beat_mode   = bus.in_first ? bus.task_ctrl : r_mode;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.overflow  = r_overflow;
    assign bus.proto_err = r_proto_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Packet framing: restarts, orphan beats and reserved packets never reach S1.
    always_comb begin
        w_state_next = r_state;
        w_restart    = 1'b0;
        w_orphan     = 1'b0;
        w_push       = 1'b0;
        w_rsvd_end   = 1'b0;
        if (w_accept) begin
            if (bus.in_first) begin
                w_restart    = (r_state == StOpen);
                w_state_next = bus.in_last ? StIdle : StOpen;
            end else if (r_state == StIdle) begin
                w_orphan = 1'b1;
            end else if (bus.in_last) begin
                w_state_next = StIdle;
            end
            w_push     = !w_orphan && (w_beat_mode != TASK_RSVD);
            w_rsvd_end = !w_orphan && bus.in_last && (w_beat_mode == TASK_RSVD);
        end
    end

    always_comb begin : p_terms
        logic signed [DATA_WIDTH-1:0] w_la, w_lb;
        w_terms = '0;
        w_la    = '0;
        w_lb    = '0;
        for (int i = 0; i < NUM_MACS; i++) begin
            w_la = bus.a[i*DATA_WIDTH +: DATA_WIDTH];
            w_lb = bus.b[i*DATA_WIDTH +: DATA_WIDTH];
            if (w_beat_mode == TASK_DOT) begin
                w_terms[i*TERM_W +: TERM_W] = TERM_W'(w_la) * TERM_W'(w_lb);
            end else begin
                w_terms[i*TERM_W +: TERM_W] = TERM_W'(w_la);
            end
        end
    end

    pe_reduce_tree #(
        .NUM_MACS (NUM_MACS),
        .TERM_W   (TERM_W)
    ) u_reduce (
        .i_terms  (r_s1_terms),
        .i_is_max (r_s1_mode == TASK_MAX),
        .o_value  (w_s1_value)
    );

    always_comb begin
        w_beat_ext = ACC_WIDTH'(r_s2_value);
        if (r_s2_first) begin
            w_acc_next = w_beat_ext;
        end else if (r_s2_mode == TASK_MAX) begin
            w_acc_next = (w_beat_ext > r_acc) ? w_beat_ext : r_acc;
        end else begin
            w_acc_next = r_acc + w_beat_ext;
        end
        w_shifted = w_acc_next >>> OUT_SHIFT;
        w_sat_hi  = w_shifted > SAT_MAX;
        w_sat_lo  = w_shifted < SAT_MIN;
        if (w_sat_hi) begin
            w_result = SAT_MAX[OUT_WIDTH-1:0];
        end else if (w_sat_lo) begin
            w_result = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            w_result = w_shifted[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode      <= TASK_DOT;
            r_proto_err <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_first  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_mode   <= TASK_DOT;
            r_s1_terms  <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_first  <= 1'b0;
            r_s2_last   <= 1'b0;
            r_s2_mode   <= TASK_DOT;
            r_s2_value  <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_proto_err <= w_restart || w_orphan || w_rsvd_end;
            if (w_accept && bus.in_first) begin
                r_mode <= bus.task_ctrl;
            end
            // A held result freezes the whole pipe; in_ready is low meanwhile.
            if (!w_stall) begin
                r_s1_valid  <= w_push;
                r_s1_first  <= bus.in_first;
                r_s1_last   <= bus.in_last;
                r_s1_mode   <= w_beat_mode;
                r_s1_terms  <= w_terms;
                r_s2_valid  <= r_s1_valid;
                r_s2_first  <= r_s1_first;
                r_s2_last   <= r_s1_last;
                r_s2_mode   <= r_s1_mode;
                r_s2_value  <= w_s1_value;
                r_out_valid <= r_s2_valid && r_s2_last;
                if (r_s2_valid) begin
                    r_acc <= w_acc_next;
                end
                if (r_s2_valid && r_s2_last) begin
                    r_result   <= w_result;
                    r_overflow <= w_sat_hi || w_sat_lo;
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_mvm_accum.sv
// Self-checking bench for pe_mvm_accum: directed cases plus randomized packets vs a packet model.
module tb_pe_mvm_accum;

    localparam int unsigned DW  = 8;
    localparam int unsigned NM  = 8;
    localparam int unsigned AW  = 32;
    localparam int unsigned OW  = 16;
    localparam int unsigned OSH = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    pe_mvm_accum_if #(.DATA_WIDTH(DW), .NUM_MACS(NM), .OUT_WIDTH(OW)) bus ();

    pe_mvm_accum #(
        .DATA_WIDTH (DW),
        .NUM_MACS   (NM),
        .ACC_WIDTH  (AW),
        .OUT_WIDTH  (OW),
        .OUT_SHIFT  (OSH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Packet-level reference model.
    typedef struct {
        longint res;
        bit     ovf;
    } exp_t;

    exp_t                    exp_q[$];
    logic signed [DW-1:0]    la[NM];
    logic signed [DW-1:0]    lb[NM];
    logic signed [AW-1:0]    m_acc = '0;
    bit                      m_open = 0;
    logic [1:0]              m_mode = 2'b00;
    int                      exp_perr = 0;
    int                      exp_outs = 0;
    int                      seen_perr = 0;
    int                      n_out = 0;
    int                      t_acc = 0;
    bit                      bp_en = 0;
    logic                    rdy_ctl = 1'b1;

    function automatic void model_beat(input bit first, input bit last, input logic [1:0] mode);
        longint               v = 0;
        longint               sh;
        longint               maxv = (64'sd1 <<< (OW - 1)) - 1;
        longint               minv = -(64'sd1 <<< (OW - 1));
        logic signed [AW-1:0] v32;
        bit                   err = 0;
        bit                   take = 1;
        exp_t                 e;
        if (first) begin
            err    = m_open;
            m_mode = mode;
            m_open = !last;
        end else if (!m_open) begin
            err  = 1;
            take = 0;
        end else if (last) begin
            m_open = 0;
        end
        if (take && m_mode == 2'b11) begin
            take = 0;
            if (last) err = 1;
        end
        if (err) exp_perr++;
        if (!take) return;
        case (m_mode)
            2'b00: for (int i = 0; i < NM; i++) v += longint'(la[i]) * longint'(lb[i]);
            2'b01: for (int i = 0; i < NM; i++) v += longint'(la[i]);
            default: begin
                v = la[0];
                for (int i = 1; i < NM; i++) if (la[i] > v) v = la[i];
            end
        endcase
        v32 = AW'(v);
        if (first) m_acc = v32;
        else if (m_mode == 2'b10) m_acc = (v32 > m_acc) ? v32 : m_acc;
        else m_acc = m_acc + v32;
        if (last) begin
            sh = longint'(m_acc) >>> OSH;
            if (sh > maxv) begin e.res = maxv; e.ovf = 1; end
            else if (sh < minv) begin e.res = minv; e.ovf = 1; end
            else begin e.res = sh; e.ovf = 0; end
            exp_q.push_back(e);
            exp_outs++;
        end
    endfunction

    task automatic model_reset();
        m_open = 0;
        exp_q.delete();
    endtask

    // out_ready lands 2 units after the edge so bench steps at +1 take effect the same cycle.
    always @(posedge clk) begin
        #2;
        bus.out_ready = bp_en ? ($urandom_range(0, 3) != 0) : rdy_ctl;
    end

    always @(negedge clk) begin
        if (rst_n && bus.proto_err) seen_perr++;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            exp_t e;
            n_out++;
            if (exp_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("result", $signed(bus.result), e.res);
                check("overflow", bus.overflow, e.ovf);
            end
        end
    end

    task automatic drive_lanes();
        for (int i = 0; i < NM; i++) begin
            bus.a[i*DW +: DW] = la[i];
            bus.b[i*DW +: DW] = lb[i];
        end
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < NM; i++) begin
            la[i] = DW'($urandom);
            lb[i] = DW'($urandom);
        end
    endtask

    // Called at edge+1; returns at edge+1 after the accepting edge, t_acc = that edge.
    task automatic send_beat(input bit first, input bit last, input logic [1:0] mode);
        bit done = 0;
        int waited = 0;
        drive_lanes();
        bus.in_first  = first;
        bus.in_last   = last;
        bus.task_ctrl = mode;
        bus.in_valid  = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                model_beat(first, last, mode);
                done = 1;
            end
            @(posedge clk);
            #1;
            if (done) t_acc = cyc;
            waited++;
            if (!done && waited > 200) begin
                check("accept_timeout", waited, 0);
                done = 1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit seen);
        seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen = 1;
        end
        check("out_seen", seen, 1);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            step(1);
            w++;
        end
        check("drain", exp_q.size(), 0);
        step(2);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit seen;
        int p0, o0, cnt;
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.in_last   = 1'b0;
        bus.task_ctrl = 2'b00;
        bus.a         = '0;
        bus.b         = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_proto_err", bus.proto_err, 0);
        check("rst_result", bus.result, 0);
        check("rst_overflow", bus.overflow, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", bus.in_ready, 1);
        step(1);

        // Single-beat dot product, latency: out_valid visible 3 cycles after acceptance cycle
        for (int i = 0; i < NM; i++) begin la[i] = 3; lb[i] = -2; end
        send_beat(1, 1, 2'b00);
        p0 = t_acc;
        wait_out(seen);
        check("latency_edges", cyc - p0, 2);
        check("dot_res", $signed(bus.result), -48);
        check("dot_ovf", bus.overflow, 0);
        step(1);

        // Four beats of 127*127 saturate
        for (int i = 0; i < NM; i++) begin la[i] = 127; lb[i] = 127; end
        for (int k = 0; k < 4; k++) send_beat(k == 0, k == 3, 2'b00);
        wait_out(seen);
        check("sat_res", $signed(bus.result), 32767);
        check("sat_ovf", bus.overflow, 1);
        step(1);

        // Max over two beats; task_ctrl on the second beat must be ignored
        for (int i = 0; i < NM; i++) begin la[i] = DW'(i - 5); lb[i] = DW'($urandom); end
        send_beat(1, 0, 2'b10);
        for (int i = 0; i < NM; i++) la[i] = 0;
        la[0] = -1;
        la[1] = 9;
        send_beat(0, 1, 2'b00);
        wait_out(seen);
        check("max_res", $signed(bus.result), 9);
        check("max_ovf", bus.overflow, 0);
        step(1);

        // Output stall for 5 cycles, then back-to-back results
        rdy_ctl = 1'b0;
        step(1);
        fork
            begin
                rand_lanes(); send_beat(1, 1, 2'b01);
                rand_lanes(); send_beat(1, 1, 2'b00);
                rand_lanes(); send_beat(1, 1, 2'b10);
            end
            begin
                wait_out(seen);
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    check("stall_valid", bus.out_valid, 1);
                    check("stall_in_ready", bus.in_ready, 0);
                    if (exp_q.size() > 0) check("stall_res", $signed(bus.result), exp_q[0].res);
                end
                @(posedge clk);
                #1 rdy_ctl = 1'b1;
                @(negedge clk);
                @(negedge clk);
                check("b2b_valid", bus.out_valid, 1);
            end
        join
        step(1);
        drain();

        // in_first inside an open packet restarts it
        p0 = seen_perr;
        rand_lanes(); send_beat(1, 0, 2'b01);
        rand_lanes(); send_beat(1, 1, 2'b01);
        step(4);
        check("restart_perr", seen_perr - p0, 1);
        drain();

        // Non-first beat with no open packet is dropped
        p0 = seen_perr;
        o0 = n_out;
        rand_lanes(); send_beat(0, 1, 2'b01);
        step(6);
        check("orphan_perr", seen_perr - p0, 1);
        check("orphan_drop", n_out - o0, 0);

        // Reset during beat 2 of 3
        rand_lanes(); send_beat(1, 0, 2'b00);
        rand_lanes(); drive_lanes();
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_valid = 1'b1;
        rst_n        = 1'b0;
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        model_reset();
        rand_lanes(); send_beat(0, 1, 2'b00);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) cnt++;
        end
        check("post_rst_quiet", cnt, 0);
        step(1);
        rand_lanes(); send_beat(1, 0, 2'b01);
        rand_lanes(); send_beat(0, 1, 2'b01);
        drain();

        // Randomized packets with bubbles and random backpressure
        bp_en = 1;
        for (int p = 0; p < 40; p++) begin
            int len = $urandom_range(1, 4);
            logic [1:0] md = 2'($urandom_range(0, 3));
            for (int k = 0; k < len; k++) begin
                rand_lanes();
                send_beat(k == 0, k == len - 1, (k == 0) ? md : 2'($urandom));
                if ($urandom_range(0, 3) == 0) step($urandom_range(1, 3));
            end
        end
        bp_en = 0;
        step(2);
        drain();

        check("perr_count", seen_perr, exp_perr);
        check("out_count", n_out, exp_outs);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
